// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, FSM states and the
// registered flag bundle. Used by alu_pipe and alu_mul_seq.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_AND = 5'd2,
        OP_OR  = 5'd3,
        OP_XOR = 5'd4,
        OP_NOT = 5'd5,
        OP_SLL = 5'd6,
        OP_SRL = 5'd7,
        OP_SRA = 5'd8,
        OP_INC = 5'd9,
        OP_DEC = 5'd10,
        OP_MUL = 5'd11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic sign;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier. A start pulse loads the operands;
// one partial product is folded in per cycle and done rises on the cycle in
// which the last partial product is being added, with product showing the
// complete 2*WIDTH-bit result during that cycle.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    import alu_pkg::*;

    localparam int CW = $clog2(WIDTH);

    logic                 running;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mplier;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign done     = running && (count == CW'(WIDTH - 1));
    assign product  = acc_next;

    // Operand load on start, then one shift-add step per cycle until done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            count   <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
        end else if (running) begin
            acc     <= acc_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            count   <= count + CW'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with a registered output slot. Single-cycle ops land in the
// slot on the accepting edge; MUL runs through alu_mul_seq for WIDTH cycles.
// Build option: define ALU_MUL_EN to include the multiplier; without it
// opcode 11 is reported as illegal and busy stays low.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             sign,
    output logic             err,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_e             state;
    state_e             state_next;
    logic               accept;
    logic               is_mul;
    logic               load_slot;
    logic               illegal;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH:0]     inc_w;
    logic [WIDTH:0]     dec_w;
    logic [WIDTH:0]     sll_w;
    logic [WIDTH:0]     srl_w;
    logic [WIDTH:0]     sra_w;
    logic [WIDTH-1:0]   alu_res;
    flags_t             alu_flags;
    logic [WIDTH-1:0]   slot_res;
    logic [WIDTH-1:0]   slot_res_next;
    flags_t             slot_flags;
    flags_t             slot_flags_next;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid && in_ready;

    // One extra bit on each arithmetic/shift path catches carry or the last
    // bit shifted out; a zero shift leaves that extra bit at 0.
    assign shamt = b[SHW-1:0];
    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign inc_w = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_w = {1'b0, a} + {1'b0, {WIDTH{1'b1}}};
    assign sll_w = {1'b0, a} << shamt;
    assign srl_w = {a, 1'b0} >> shamt;
    assign sra_w = $unsigned($signed({a, 1'b0}) >>> shamt);

`ifdef ALU_MUL_EN
    logic                 mul_done;
    logic [2*WIDTH-1:0]   product;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );

    assign is_mul    = (op == OP_MUL);
    assign busy      = (state == ST_MUL);
    assign load_slot = (accept && !is_mul) || mul_done;
`else
    assign is_mul    = 1'b0;
    assign busy      = 1'b0;
    assign load_slot = accept;
`endif

    // Single-cycle operation datapath; anything not decoded here is illegal.
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        illegal   = 1'b0;
        case (op)
            OP_ADD:  {alu_flags.carry, alu_res} = add_w;
            OP_SUB:  {alu_flags.carry, alu_res} = sub_w;
            OP_INC:  {alu_flags.carry, alu_res} = inc_w;
            OP_DEC:  {alu_flags.carry, alu_res} = dec_w;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_SLL:  {alu_flags.carry, alu_res} = sll_w;
            OP_SRL:  {alu_res, alu_flags.carry} = srl_w;
            OP_SRA:  {alu_res, alu_flags.carry} = sra_w;
            default: illegal = 1'b1;
        endcase
        alu_flags.err  = illegal;
        alu_flags.zero = !illegal && (alu_res == '0);
        alu_flags.sign = !illegal && alu_res[WIDTH-1];
    end

    // Select what the slot captures: the ALU path, or the finished product.
    always_comb begin
        slot_res_next   = alu_res;
        slot_flags_next = alu_flags;
`ifdef ALU_MUL_EN
        if (state == ST_MUL) begin
            slot_res_next         = product[WIDTH-1:0];
            slot_flags_next.carry = |product[2*WIDTH-1:WIDTH];
            slot_flags_next.zero  = (product[WIDTH-1:0] == '0);
            slot_flags_next.sign  = product[WIDTH-1];
            slot_flags_next.err   = 1'b0;
        end
`endif
    end

    // Output slot: written only when a result completes, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_res   <= '0;
            slot_flags <= '0;
        end else if (load_slot) begin
            slot_res   <= slot_res_next;
            slot_flags <= slot_flags_next;
        end
    end

    assign result = slot_res;
    assign carry  = slot_flags.carry;
    assign zero   = slot_flags.zero;
    assign sign   = slot_flags.sign;
    assign err    = slot_flags.err;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; HOLD can hand straight over to a new op.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = is_mul ? ST_MUL : ST_HOLD;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    state_next = ST_HOLD;
                end
            end
`endif
            ST_HOLD: begin
                if (accept) begin
                    state_next = is_mul ? ST_MUL : ST_HOLD;
                end else if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
